// File: rtl/mc_pkg.sv
// Shared types and defaults for the memory access controller.
//   mc_state_e     : sequencer state encoding
//   DATA_W_DEF     : default MDR / memory data width
//   ADDR_W_DEF     : default MAR address width
//   TIMEOUT_DEF    : default ACCESS timeout in cycles (0 = no timeout)
//   mc_cnt_width() : counter width able to hold 0..limit (at least 1 bit)
package mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } mc_state_e;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 8;

  function automatic int mc_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mc_timeout_counter.sv
// Saturating ACCESS-phase cycle counter with an expiry flag.
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   clr_i     : clear count to zero (wins over en_i)
//   en_i      : count this cycle
//   expired_o : count has reached LIMIT-1 (never set when LIMIT == 0)
module mc_timeout_counter
  import mc_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF,
  parameter int CNT_W = mc_cnt_width(LIMIT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Hold at all-ones instead of wrapping so a stuck access can never
  // re-arm the expiry compare.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (en_i && ~&cnt_q)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  generate
    if (LIMIT > 0) begin : g_lim
      assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));
    end else begin : g_nolim
      assign expired_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR/memory access sequencer. Takes one request at a time, strobes
// MAR (and MDR for writes), holds the memory enable until ready or
// timeout, then issues a single-cycle response.
//   MC_clock / MC_reset         : clock, synchronous active-high reset
//   MC_req_*                    : request handshake and fields
//   MC_mar_* / MC_mdr_*         : MAR/MDR load strobes, data, bus drive
//   MC_mem_*                    : memory enable/write enable, ready, rdata
//   MC_resp_*                   : response pulse, read data, error flag
//   MC_busy                     : sequencer not idle
module mem_access_ctrl
  import mc_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              MC_clock,
  input  logic              MC_reset,
  input  logic              MC_req_valid,
  output logic              MC_req_ready,
  input  logic              MC_req_write,
  input  logic [ADDR_W-1:0] MC_req_addr,
  input  logic [DATA_W-1:0] MC_req_wdata,
  output logic              MC_mar_load,
  output logic [ADDR_W-1:0] MC_mar_addr,
  output logic              MC_mdr_load,
  output logic [DATA_W-1:0] MC_mdr_wdata,
  output logic              MC_mdr_bus_out_en,
  output logic              MC_mem_en,
  output logic              MC_mem_we,
  input  logic              MC_mem_ready,
  input  logic [DATA_W-1:0] MC_mem_rdata,
  output logic              MC_resp_valid,
  output logic [DATA_W-1:0] MC_resp_rdata,
  output logic              MC_resp_error,
  output logic              MC_busy
);

  mc_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;
  logic              expired;

  mc_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk_i     (MC_clock),
    .rst_i     (MC_reset),
    .clr_i     (state_q == ST_ADDR),
    .en_i      (state_q == ST_ACCESS),
    .expired_o (expired)
  );

  always_ff @(posedge MC_clock) begin
    if (MC_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // ready is implied here: IDLE and not in reset
          if (MC_req_valid) begin
            addr_q  <= MC_req_addr;
            wdata_q <= MC_req_wdata;
            write_q <= MC_req_write;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: state_q <= ST_ACCESS;
        ST_ACCESS: begin
          // ready beats a simultaneous timeout
          if (MC_mem_ready) begin
            if (!write_q) rdata_q <= MC_mem_rdata;
            error_q <= 1'b0;
            state_q <= ST_RESP;
          end else if (expired) begin
            rdata_q <= '0;
            error_q <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ready is gated by reset so it stays low for the whole reset window
  assign MC_req_ready      = ~MC_reset & (state_q == ST_IDLE);
  assign MC_mar_load       = (state_q == ST_ADDR);
  assign MC_mar_addr       = addr_q;
  assign MC_mdr_load       = (state_q == ST_ADDR) & write_q;
  assign MC_mdr_wdata      = wdata_q;
  assign MC_mem_en         = (state_q == ST_ACCESS);
  assign MC_mem_we         = (state_q == ST_ACCESS) & write_q;
  assign MC_resp_valid     = (state_q == ST_RESP);
  assign MC_mdr_bus_out_en = (state_q == ST_RESP) & ~write_q & ~error_q;
  assign MC_resp_rdata     = rdata_q;
  assign MC_resp_error     = error_q;
  assign MC_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        mar_load, mdr_load, bus_en, mem_en, mem_we, mem_ready;
  logic [15:0] mar_addr, mdr_wdata, mem_rdata, resp_rdata;
  logic        resp_valid, resp_error, busy;

  mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
    .MC_clock(clk), .MC_reset(rst),
    .MC_req_valid(req_valid), .MC_req_ready(req_ready),
    .MC_req_write(req_write), .MC_req_addr(req_addr), .MC_req_wdata(req_wdata),
    .MC_mar_load(mar_load), .MC_mar_addr(mar_addr),
    .MC_mdr_load(mdr_load), .MC_mdr_wdata(mdr_wdata),
    .MC_mdr_bus_out_en(bus_en), .MC_mem_en(mem_en), .MC_mem_we(mem_we),
    .MC_mem_ready(mem_ready), .MC_mem_rdata(mem_rdata),
    .MC_resp_valid(resp_valid), .MC_resp_rdata(resp_rdata),
    .MC_resp_error(resp_error), .MC_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // scoreboard of expected responses
  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic        bus;
    logic        chk_rdata;
    int          at;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_cycle", cyc, e.at);
        check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
        check("resp_bus_en", {31'd0, bus_en}, {31'd0, e.bus});
        check("resp_mem_en", {31'd0, mem_en}, 32'd0);
        if (e.chk_rdata) check("resp_rdata", {16'd0, resp_rdata}, {16'd0, e.rdata});
      end
    end else begin
      check("bus_en_idle", {31'd0, bus_en}, 32'd0);
    end
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          rdy_at;    // ACCESS cycle index of mem_ready, -1 = never
    logic        exp_err;
    logic [15:0] exp_rdata;
    logic        chk_rdata;
    logic        exp_bus;
    int          lat;       // T0 -> resp_valid
  } vec_t;

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_txn(input vec_t v);
    int   c0;
    int   last;
    exp_t e;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    mem_ready = 1'b0;
    c0 = cyc;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.bus = v.exp_bus;
    e.chk_rdata = v.chk_rdata; e.at = c0 + v.lat;
    sb.push_back(e);
    // T1: ADDR; a stray mem_ready here must be ignored
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 16'h5555; req_wdata = 16'h6666;
    mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("addr_mar_load", {31'd0, mar_load}, 32'd1);
    check("addr_mar_addr", {16'd0, mar_addr}, {16'd0, v.addr});
    check("addr_mdr_load", {31'd0, mdr_load}, {31'd0, v.wr});
    if (v.wr) check("addr_mdr_wdata", {16'd0, mdr_wdata}, {16'd0, v.wdata});
    check("addr_mem_en", {31'd0, mem_en}, 32'd0);
    check("addr_req_ready", {31'd0, req_ready}, 32'd0);
    last = (v.rdy_at >= 0 && v.rdy_at < 8) ? v.rdy_at : 7;
    for (int i = 0; i <= last; i++) begin
      @(posedge clk); #1;
      mem_ready = (i == v.rdy_at);
      mem_rdata = (i == v.rdy_at) ? v.rdata : 16'hDEAD;
      @(negedge clk);
      check("acc_mem_en", {31'd0, mem_en}, 32'd1);
      check("acc_mem_we", {31'd0, mem_we}, {31'd0, v.wr});
      check("acc_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 16'h0040, 16'h0000, 16'hBEEF,  0, 1'b0, 16'hBEEF, 1'b1, 1'b1,  3};
    vecs[1] = '{1'b1, 16'h1234, 16'hA5A5, 16'h0000,  2, 1'b0, 16'h0000, 1'b0, 1'b0,  5};
    vecs[2] = '{1'b0, 16'h0F00, 16'h0000, 16'h0000, -1, 1'b1, 16'h0000, 1'b1, 1'b0, 10};
    vecs[3] = '{1'b0, 16'h0080, 16'h0000, 16'h1357,  7, 1'b0, 16'h1357, 1'b1, 1'b1, 10};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0001,  3, 1'b0, 16'h0001, 1'b1, 1'b1,  6};
    vecs[5] = '{1'b1, 16'h0000, 16'h3C3C, 16'h0000, -1, 1'b1, 16'h0000, 1'b1, 1'b0, 10};
    vecs[6] = '{1'b0, 16'h8000, 16'h0000, 16'hFFFF,  1, 1'b0, 16'hFFFF, 1'b1, 1'b1,  4};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outs", {26'd0, mar_load, mdr_load, mem_en, mem_we, resp_valid, resp_error}, 32'd0);
    check("rst_data", {mar_addr, mdr_wdata | resp_rdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // back-to-back with req_valid held high
    begin
      int c0;
      exp_t e;
      wait_ready();
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0A0A;
      mem_ready = 1'b1; mem_rdata = 16'h1111;
      c0 = cyc;
      e.rdata = 16'h1111; e.err = 1'b0; e.bus = 1'b1; e.chk_rdata = 1'b1;
      e.at = c0 + 3; sb.push_back(e);
      e.at = c0 + 7; sb.push_back(e);
      @(negedge clk);
      check("b2b_t0_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_addr = 16'h0B0B;
      @(negedge clk);
      check("b2b_t1_mar_addr", {16'd0, mar_addr}, 32'h0A0A);
      for (int t = 1; t <= 3; t++) begin
        if (t > 1) @(negedge clk);
        check("b2b_busy_ready", {30'd0, busy, req_ready}, 32'd2);
      end
      @(negedge clk);
      check("b2b_t4_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("b2b_t5_mar", {15'd0, mar_load, mar_addr}, 32'h10B0B);
      repeat (3) @(posedge clk);
      #1 mem_ready = 1'b0;
    end

    // reset during a waiting read: no response, everything cleared
    begin
      wait_ready();
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;          // T2
      @(posedge clk); #1;          // T3
      rst = 1'b1;
      @(negedge clk);
      check("mid_pre_mem_en", {31'd0, mem_en}, 32'd1);
      @(negedge clk);              // T4
      check("mid_req_ready", {31'd0, req_ready}, 32'd0);
      check("mid_ctrl", {25'd0, busy, mar_load, mdr_load, mem_en, mem_we, resp_valid, resp_error}, 32'd0);
      check("mid_data", {mar_addr, resp_rdata}, 32'd0);
      @(negedge clk);
      check("mid_req_ready2", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    end
    run_txn('{1'b0, 16'h0002, 16'h0000, 16'h2222, 1, 1'b0, 16'h2222, 1'b1, 1'b1, 4});

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer for the MAR/MDR/memory datapath.
- Accepts one read or write request at a time from the control unit.
- Drives MAR load, MDR load and memory enables, and waits on the memory ready handshake with a timeout.
- Returns one response per request: read data or an error flag, with MDR bus drive for reads.

Parameters:
- DATA_W, 16, data width of the MDR and memory path
- ADDR_W, 16, address width of the MAR
- TIMEOUT_CYCLES, 8, maximum cycles in ACCESS before an error is flagged; 0 disables the timeout

Ports:
- MC_clock  in  1  system clock, rising edge
- MC_reset  in  1  synchronous, active-high reset
- MC_req_valid  in  1  request present
- MC_req_ready  out  1  controller can accept a request
- MC_req_write  in  1  1 = write, 0 = read
- MC_req_addr  in  ADDR_W  request address
- MC_req_wdata  in  DATA_W  write data
- MC_mar_load  out  1  MAR capture strobe
- MC_mar_addr  out  ADDR_W  address presented to MAR
- MC_mdr_load  out  1  MDR capture strobe for write data
- MC_mdr_wdata  out  DATA_W  write data presented to MDR
- MC_mdr_bus_out_en  out  1  MDR tri-state bus drive enable
- MC_mem_en  out  1  memory access enable
- MC_mem_we  out  1  memory write enable
- MC_mem_ready  in  1  memory completes the access this cycle
- MC_mem_rdata  in  DATA_W  memory read data
- MC_resp_valid  out  1  one-cycle response pulse
- MC_resp_rdata  out  DATA_W  read data of the last response
- MC_resp_error  out  1  last response timed out
- MC_busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock (MC_clock); MC_reset is synchronous and active-high.
- Reset value of every output is 0, including MC_req_ready while MC_reset is high. MC_req_ready is 1 on the first cycle after reset deasserts.
- FSM states: IDLE, ADDR, ACCESS, RESP. Control outputs are Moore decodes of state plus latched request fields.
- IDLE:
  - MC_req_ready=1.
  - On MC_req_valid & MC_req_ready: latch addr, write and wdata; go to ADDR.
  - MC_req_valid in any other state is ignored, never accepted.
- ADDR (exactly 1 cycle):
  - MC_mar_load=1 with MC_mar_addr=latched addr.
  - If write, also MC_mdr_load=1 with MC_mdr_wdata=latched wdata.
  - Clear the timeout counter; go to ACCESS.
- ACCESS:
  - MC_mem_en=1; MC_mem_we=latched write.
  - Counter increments each cycle.
  - MC_mem_ready=1: for reads, capture MC_mem_rdata into the response register; error=0; go to RESP.
  - Else, if TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1: error=1, rdata=0; go to RESP.
  - Ready and timeout in the same cycle: ready wins, no error.
  - MC_mem_ready outside ACCESS is ignored.
- RESP (exactly 1 cycle):
  - MC_resp_valid=1.
  - MC_mdr_bus_out_en=1 only for reads without error.
  - Go to IDLE.
- Hold rules: MC_resp_rdata and MC_resp_error hold until the next RESP. MC_mar_addr and MC_mdr_wdata hold the latched values; they are 0 after reset.
- Latency: accept at cycle T0, ADDR at T1, ACCESS from T2, resp_valid at T3 + wait states. Minimum request-to-request spacing is 4 cycles.
- Counter width is clog2(TIMEOUT_CYCLES+1); the counter saturates, never wraps.
- Reset mid-operation: the next edge returns to IDLE, clears all outputs and registers, and issues no response. An abandoned access is not retried.

Decomposition:
- Shared package mc_pkg:
  - state enum (IDLE, ADDR, ACCESS, RESP)
  - default widths DATA_W/ADDR_W
  - TIMEOUT_CYCLES default
- One natural sub-module: mc_timeout_counter (clear, enable, saturating count, expired flag for a parameterised limit).

Test Plan:
- Zero-wait read:
  - Stimulus: addr 0x0040, mem_ready=1 with rdata 0xBEEF in the first ACCESS cycle.
  - Response: mar_load and mar_addr=0x0040 at T1; mem_en=1, mem_we=0 at T2; resp_valid and mdr_bus_out_en at T3; resp_rdata=0xBEEF, error=0.
- Write with 2 wait states:
  - Stimulus: addr 0x1234, wdata 0xA5A5, ready at T4.
  - Response: mar_load and mdr_load at T1 with mdr_wdata=0xA5A5; mem_en=mem_we=1 for T2–T4; resp_valid at T5; bus_out_en stays 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, mem_ready never asserted.
  - Response: mem_en high for exactly 8 cycles (T2–T9); resp_valid at T10 with error=1, rdata=0x0000.
- Ready on the final timeout cycle:
  - Stimulus: mem_ready=1 at T9.
  - Response: resp_valid at T10 with error=0 and the captured rdata.
- Reset mid-ACCESS:
  - Stimulus: assert MC_reset at T3 of a waiting read.
  - Response: at the T4 edge all outputs are 0, there is no resp_valid, and req_ready=0 while reset is high. After release, a read of 0x0002 completes normally.
- Back-to-back:
  - Stimulus: req_valid held high with two requests.
  - Response: first accepted at T0; req_ready=0 for T1–T3; second accepted at T4; busy=1 throughout each access.
